// File: rtl/jtframe_spihost_pkg.sv
// jtframe_spihost_pkg: FSM states, MiST command codes and length clamp for jtframe_spi_host
package jtframe_spihost_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, NEXT, HOLD, GAP} state_t;
  localparam logic [7:0] UIO_JOYSTICK0   = 8'h02;
  localparam logic [7:0] UIO_JOYSTICK1   = 8'h03;
  localparam logic [7:0] UIO_SET_STATUS2 = 8'h1E;
  localparam logic [7:0] OSD_CMD_WRITE   = 8'h20;
  function automatic logic [2:0] clamp_len(input logic [2:0] l);
    return l > 3'd4 ? 3'd4 : l;
  endfunction
endpackage

// File: rtl/jtframe_spi_shifter.sv
// jtframe_spi_shifter: mode-0 SCK divider and MSB-first byte shifter.
// MISO capture exists only with JTFRAME_SPIHOST_RX_EN; otherwise byte_out is 0.
module jtframe_spi_shifter #(
  parameter int CLKDIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       done,
  output logic [7:0] byte_out
);
  logic [7:0] div_q, sr_q;
  logic [2:0] bit_q;
  logic       sck_q, run_q;
  logic       tick, rise;
  assign tick = run_q && div_q == 8'(CLKDIV - 1);
  assign done = tick && !sck_q && bit_q == 3'd7;
  // start raises SCK at once, so the first rise lands on the cycle after start
  assign rise = start || (tick && !sck_q && bit_q != 3'd7);
  assign sck  = sck_q;
  assign mosi = sr_q[7];
  always_ff @(posedge clk)
    if (rst) begin
      div_q <= '0;
      sr_q  <= '0;
      bit_q <= '0;
      sck_q <= 1'b0;
      run_q <= 1'b0;
    end else if (start) begin
      div_q <= '0;
      sr_q  <= byte_in;
      bit_q <= '0;
      sck_q <= 1'b1;
      run_q <= 1'b1;
    end else if (tick) begin
      div_q <= '0;
      sck_q <= !sck_q && !done;
      if (sck_q) sr_q <= sr_q << 1;
      if (!sck_q) bit_q <= bit_q + 3'd1;
      if (done) run_q <= 1'b0;
    end else if (run_q) begin
      div_q <= div_q + 8'd1;
    end
`ifdef JTFRAME_SPIHOST_RX_EN
  logic [7:0] rx_q;
  always_ff @(posedge clk)
    if (rst) rx_q <= '0;
    else if (rise) rx_q <= {rx_q[6:0], miso};
  assign byte_out = rx_q;
`else
  logic unused_rx;
  assign unused_rx = miso ^ rise;
  assign byte_out  = '0;
`endif
endmodule

// File: rtl/jtframe_spi_host.sv
// jtframe_spi_host: MiST user_io/OSD SPI initiator (command byte + 0-4 payload bytes on SS2/SS3).
// Define JTFRAME_SPIHOST_RX_EN to capture MISO bytes on rx_data/rx_valid.
module jtframe_spi_host #(
  parameter int CLKDIV = 4,
  parameter int GAP    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_sel,
  input  logic [7:0]  cmd_code,
  input  logic [2:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        busy,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        spi_sck,
  output logic        spi_di,
  input  logic        spi_do,
  output logic        spi_ss2,
  output logic        spi_ss3
);
  import jtframe_spihost_pkg::*;
  state_t      state_q, state_d;
  logic [7:0]  tmr_q, code_q, byte_in, nxt_byte, sh_byte;
  logic [31:0] data_q;
  logic [2:0]  len_q, idx_q;
  logic        sel_q, tmr_end, more, ss_act, start, sh_mosi, sh_done;
  assign more     = idx_q < len_q;
  assign nxt_byte = data_q[{idx_q[1:0], 3'b000} +: 8];
  assign tmr_end  = tmr_q == (state_q == jtframe_spihost_pkg::GAP ? 8'(GAP - 1) : 8'(CLKDIV - 1));
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      sel_q   <= 1'b0;
      code_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= state_d != state_q ? 8'd0 : tmr_q + 8'd1;
      if (cmd_valid && cmd_ready) begin
        sel_q  <= cmd_sel;
        code_q <= cmd_code;
        len_q  <= clamp_len(cmd_len);
        data_q <= cmd_data;
        idx_q  <= '0;
      end
      if (state_q == NEXT && more) idx_q <= idx_q + 3'd1;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = SETUP;
      SETUP:   if (tmr_end) state_d = SHIFT;
      SHIFT:   if (sh_done) state_d = NEXT;
      NEXT:    state_d = more ? SHIFT : HOLD;
      HOLD:    if (tmr_end) state_d = jtframe_spihost_pkg::GAP;
      default: if (tmr_end) state_d = IDLE;
    endcase
  end
  // MOSI shows the next byte's MSB during SETUP/NEXT so it is stable before the following rise
  always_comb begin
    cmd_ready = state_q == IDLE;
    busy      = state_q != IDLE;
    ss_act    = state_q inside {SETUP, SHIFT, NEXT, HOLD};
    start     = (state_q == SETUP && tmr_end) || (state_q == NEXT && more);
    byte_in   = state_q == SETUP ? code_q : nxt_byte;
    spi_di    = state_q == SETUP ? code_q[7] :
                state_q == SHIFT ? sh_mosi :
                state_q == NEXT && more ? nxt_byte[7] : 1'b0;
  end
  assign spi_ss2 = !(ss_act && !sel_q);
  assign spi_ss3 = !(ss_act && sel_q);
  jtframe_spi_shifter #(.CLKDIV(CLKDIV)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .byte_in  (byte_in),
    .miso     (spi_do),
    .sck      (spi_sck),
    .mosi     (sh_mosi),
    .done     (sh_done),
    .byte_out (sh_byte)
  );
`ifdef JTFRAME_SPIHOST_RX_EN
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  always_ff @(posedge clk)
    if (rst) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= state_q == SHIFT && sh_done;
      if (state_q == SHIFT && sh_done) rx_data_q <= sh_byte;
    end
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`else
  logic [7:0] unused_byte;
  assign unused_byte = sh_byte;
  assign rx_data     = '0;
  assign rx_valid    = 1'b0;
`endif
endmodule

// File: tb/tb_jtframe_spi_host.sv
// tb_jtframe_spi_host: vector table + random requests checked against a frame-level SPI model
module tb_jtframe_spi_host;
  localparam int CLKDIV = 4;
  localparam int GAP    = 8;
`ifdef JTFRAME_SPIHOST_RX_EN
  localparam int RXN = 1;
`else
  localparam int RXN = 0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_sel = 1'b0;
  logic [7:0]  cmd_code = '0;
  logic [2:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        cmd_ready, busy, rx_valid, spi_sck, spi_di, spi_ss2, spi_ss3;
  logic [7:0]  rx_data;
  logic        spi_do = 1'b0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  jtframe_spi_host #(.CLKDIV(CLKDIV), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_code(cmd_code), .cmd_len(cmd_len), .cmd_data(cmd_data), .busy(busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .spi_sck(spi_sck), .spi_di(spi_di),
    .spi_do(spi_do), .spi_ss2(spi_ss2), .spi_ss3(spi_ss3)
  );
  typedef struct {
    logic        sel;
    int          nb;
    logic [39:0] seq;
    int          rises;
    bit          other;
    int          first;
    int          nrx;
    logic [39:0] rx;
  } frame_t;
  frame_t frames[$];
  frame_t cur;
  int cyc_n = 0, m_fall = 0, m_rel = 0, last_gap = 0, rx_total = 0;
  logic m_act, m_pact = 1'b0, m_psck = 1'b0;
  logic [7:0] m_sr;
  // bus monitor: rebuilds each frame from SS/SCK/MOSI as a SPI target would see it
  always @(negedge clk) begin
    cyc_n++;
    m_act = !spi_ss2 || !spi_ss3;
    if (rx_valid) rx_total++;
    if (m_act && !m_pact) begin
      cur = '{default: 0};
      cur.sel = !spi_ss3;
      cur.first = -1;
      m_fall = cyc_n;
      last_gap = cyc_n - m_rel;
    end
    if (m_act) begin
      if (cur.sel ? !spi_ss2 : !spi_ss3) cur.other = 1;
      if (spi_sck && !m_psck) begin
        if (cur.rises == 0) cur.first = cyc_n - m_fall;
        m_sr = {m_sr[6:0], spi_di};
        cur.rises++;
        if (cur.rises % 8 == 0 && cur.rises <= 40) cur.seq[8*(cur.rises/8-1) +: 8] = m_sr;
      end
      if (rx_valid) begin
        if (cur.nrx < 5) cur.rx[8*cur.nrx +: 8] = rx_data;
        cur.nrx++;
      end
    end
    if (!m_act && m_pact) begin
      cur.nb = cur.rises / 8;
      frames.push_back(cur);
      m_rel = cyc_n;
    end
    m_pact = m_act;
    m_psck = spi_sck;
  end
  // responder: shifts resp out MSB-first, byte 0 first, changing after each SCK fall
  logic [39:0] resp = '0;
  int r_bit = 0, r_byte = 0;
  logic r_act, r_pact = 1'b0, r_psck = 1'b0;
  always @(negedge clk) begin
    r_act = !spi_ss2 || !spi_ss3;
    if (r_act && !r_pact) begin
      r_byte = 0;
      r_bit = 0;
      spi_do = resp[7];
    end else if (r_act && r_psck && !spi_sck) begin
      r_bit++;
      if (r_bit == 8) begin
        r_bit = 0;
        r_byte++;
      end
      spi_do = r_byte < 5 ? resp[8*r_byte + 7 - r_bit] : 1'b0;
    end
    r_pact = r_act;
    r_psck = spi_sck;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic int model_n(input logic [2:0] l);
    return 1 + (l > 3'd4 ? 4 : int'(l));
  endfunction
  function automatic logic [39:0] mask_n(input logic [39:0] v, input int n);
    return v & ((40'd1 << (8*n)) - 40'd1);
  endfunction
  function automatic int model_cyc(input int n);
    return 1 + CLKDIV + n*(16*CLKDIV + 1) + CLKDIV + GAP;
  endfunction
  task automatic run_req(input logic s, input logic [7:0] c, input logic [2:0] l, input logic [31:0] d,
                         input logic [39:0] r, output int cyc);
    int t;
    @(negedge clk);
    resp = r;
    cmd_sel = s; cmd_code = c; cmd_len = l; cmd_data = d; cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 2000) begin @(negedge clk); t++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("ss_after_accept", {spi_ss3, spi_ss2}, s ? 2'b01 : 2'b10);
    cyc = 1;
    while (!cmd_ready && cyc < 2000) begin @(negedge clk); cyc++; end
  endtask
  task automatic check_frame(input string nm, input logic s, input int n, input logic [39:0] seq,
                             input int exp_cyc, input logic [39:0] r, input int cyc);
    frame_t f;
    chk({nm, "_cycles"}, cyc, exp_cyc);
    if (frames.size() == 0) begin
      chk({nm, "_frame_seen"}, 0, 1);
      return;
    end
    f = frames.pop_front();
    chk({nm, "_sel"}, f.sel, s);
    chk({nm, "_bytes"}, f.seq, seq);
    chk({nm, "_sck_rises"}, f.rises, 8*n);
    chk({nm, "_other_ss"}, f.other, 0);
    chk({nm, "_first_rise"}, f.first, CLKDIV);
    chk({nm, "_rx_count"}, f.nrx, RXN*n);
`ifdef JTFRAME_SPIHOST_RX_EN
    chk({nm, "_rx_bytes"}, f.rx, mask_n(r, n));
`endif
  endtask
  typedef struct {
    logic sel; logic [7:0] code; logic [2:0] len; logic [31:0] data; logic [39:0] resp;
    int exp_n; logic [39:0] exp_seq; int exp_cyc;
  } vec_t;
  vec_t vt[7];
  initial begin
    int cyc, cyc2, t, n;
    logic s; logic [7:0] c; logic [2:0] l; logic [31:0] d; logic [39:0] r;
    vt[0] = '{1'b0, 8'h02, 3'd1, 32'h0000_00A5, 40'h00_0000_C35A, 2, 40'h00_0000_A502, 147};
    vt[1] = '{1'b0, 8'h02, 3'd0, 32'hFFFF_FFFF, 40'h00_0000_0081, 1, 40'h00_0000_0002, 82};
    vt[2] = '{1'b0, 8'h1E, 3'd7, 32'h4433_2211, 40'h12_3456_789A, 5, 40'h44_3322_111E, 342};
    vt[3] = '{1'b1, 8'h20, 3'd4, 32'hDEAD_BEEF, 40'hF0_0F55_AA33, 5, 40'hDE_ADBE_EF20, 342};
    vt[4] = '{1'b1, 8'h03, 3'd2, 32'h0000_8001, 40'h00_0001_FF7E, 3, 40'h00_0080_0103, 212};
    vt[5] = '{1'b0, 8'h1E, 3'd5, 32'h1234_5678, 40'h11_2233_4455, 5, 40'h12_3456_781E, 342};
    vt[6] = '{1'b1, 8'h02, 3'd3, 32'hAABB_CCDD, 40'h00_C0FF_EE01, 4, 40'h00_BBCC_DD02, 277};
    repeat (4) @(negedge clk);
    chk("rst_ss2", spi_ss2, 1);
    chk("rst_ss3", spi_ss3, 1);
    chk("rst_sck", spi_sck, 0);
    chk("rst_di", spi_di, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      run_req(vt[i].sel, vt[i].code, vt[i].len, vt[i].data, vt[i].resp, cyc);
      check_frame($sformatf("vec%0d", i), vt[i].sel, vt[i].exp_n, vt[i].exp_seq, vt[i].exp_cyc, vt[i].resp, cyc);
    end
    // back-to-back: cmd_valid stays high across two requests
    @(negedge clk);
    resp = 40'h00_0000_3CA5;
    cmd_sel = 1'b0; cmd_code = 8'h02; cmd_len = 3'd1; cmd_data = 32'h0000_0042; cmd_valid = 1'b1;
    @(negedge clk);
    chk("b2b_first_accepted", cmd_ready, 0);
    cmd_sel = 1'b1; cmd_code = 8'h20; cmd_len = 3'd2; cmd_data = 32'h0000_9988;
    cyc = 1;
    while (!cmd_ready && cyc < 2000) begin @(negedge clk); cyc++; end
    check_frame("b2b_a", 1'b0, 2, 40'h00_0000_4202, 147, 40'h00_0000_3CA5, cyc);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc2 = 1;
    while (!cmd_ready && cyc2 < 2000) begin @(negedge clk); cyc2++; end
    chk("b2b_gap_ge", last_gap >= GAP, 1);
    check_frame("b2b_b", 1'b1, 3, 40'h00_0099_8820, 212, 40'h00_0000_3CA5, cyc2);
    // reset during bit 3 of payload byte 1 (20th SCK rise overall)
    @(negedge clk);
    resp = '0;
    cmd_sel = 1'b0; cmd_code = 8'h1E; cmd_len = 3'd4; cmd_data = 32'h0F0E_0D0C; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (cur.rises < 20 && t < 2000) begin @(negedge clk); t++; end
    chk("midrst_reached_bit3", t < 2000, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ss2", spi_ss2, 1);
    chk("midrst_ss3", spi_ss3, 1);
    chk("midrst_sck", spi_sck, 0);
    chk("midrst_ready", cmd_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    frames.delete();
    run_req(1'b0, 8'h03, 3'd4, 32'hCAFE_F00D, 40'h55_6677_8899, cyc);
    check_frame("after_rst", 1'b0, 5, 40'hCA_FEF0_0D03, 342, 40'h55_6677_8899, cyc);
    // random requests against the frame model
    for (int i = 0; i < 20; i++) begin
      s = 1'($urandom);
      c = 8'($urandom);
      l = 3'($urandom_range(0, 7));
      d = $urandom;
      r = {8'($urandom), $urandom};
      n = model_n(l);
      run_req(s, c, l, d, r, cyc);
      check_frame($sformatf("rnd%0d", i), s, n, mask_n({d, c}, n), model_cyc(n), r, cyc);
    end
`ifndef JTFRAME_SPIHOST_RX_EN
    chk("rx_never_pulses", rx_total, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end
endmodule

// File: doc/jtframe_spi_host.md
# jtframe_spi_host

SPI initiator that drives the MiST-style user_io/OSD SPI bus from inside the FPGA, taking the role normally played by the ARM I/O controller. It converts single-command requests (command byte plus 0–4 payload bytes) into framed SPI transactions on SS2 (user_io) or SS3 (OSD), and optionally captures the bytes returned on the core's SPI_DO line. It is used on DEMISTIFY-style targets, where a local controller must feed joystick, status and OSD data to jtframe_mist.

## Interface
Parameters:
- CLKDIV, 4: clk cycles per SCK half-period; legal range 1–255.
- GAP, 8: idle clk cycles with both selects high between transactions; legal range 1–255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  a request is present.
- cmd_ready  out  1  the block accepts a request in the cycle where `cmd_valid & cmd_ready`.
- cmd_sel  in  1  target select: 0 → spi_ss2, 1 → spi_ss3.
- cmd_code  in  8  command byte; always sent first.
- cmd_len  in  3  number of payload bytes, 0–4; values 5–7 are clamped to 4.
- cmd_data  in  32  payload; byte [7:0] is sent first (little-endian byte order, MSB-first within each byte).
- busy  out  1  a transaction is in progress, from acceptance until the end of the gap.
- rx_data  out  8  last byte received on spi_do.
- rx_valid  out  1  one-cycle strobe when rx_data updates.
- spi_sck  out  1  SPI clock.
- spi_di  out  1  MOSI; drives the core's SPI_DI.
- spi_do  in  1  MISO; driven by the core's SPI_DO.
- spi_ss2  out  1  user_io select, active low.
- spi_ss3  out  1  OSD select, active low.

## Operation
- SPI mode 0. SCK idles low. MOSI changes after each SCK falling edge, or during setup. MISO is sampled on each SCK rising edge.
- State machine:
  - IDLE: cmd_ready=1. On acceptance, latch sel, code, clamped len and data, then go to SETUP.
  - SETUP: assert the selected SS low and present the MSB of cmd_code on spi_di. Hold for CLKDIV cycles, then go to SHIFT.
  - SHIFT: clock 8 bits. For each bit, SCK is high for CLKDIV cycles and low for CLKDIV cycles. After bit 7 falls, go to NEXT.
  - NEXT: one cycle. If bytes remain, load the next payload byte and return to SHIFT with no extra SCK delay. Otherwise go to HOLD.
  - HOLD: keep SS low for CLKDIV cycles, then release it and go to GAP.
  - GAP: both SS high for GAP cycles, then go to IDLE.
- Bytes are sent in the order cmd_code, data[7:0], data[15:8], data[23:16], data[31:24], truncated to len payload bytes.
- Only the selected SS toggles. The other SS stays high throughout.
- A new request is never accepted while busy. cmd_ready=0 in every state except IDLE.
- Reset mid-transaction aborts immediately. On the next cycle both SS are high and SCK is low; no partial-frame recovery is attempted.

## Timing
- Reset values:
  - spi_sck=0, spi_di=0, spi_ss2=1, spi_ss3=1.
  - cmd_ready=1, busy=0.
  - rx_data=0, rx_valid=0.
- busy rises on the cycle after acceptance.
- Transaction length from acceptance to cmd_ready high again: 1 + CLKDIV + (1+len)·(16·CLKDIV + 1) + CLKDIV + GAP cycles.
- With CLKDIV=4, GAP=8 and len=0, that is 1+4+65+4+8 = 82 cycles.
- SS falls on the cycle after acceptance. The first SCK rise is CLKDIV cycles later.
- rx_valid pulses in the NEXT cycle of each byte, including the command byte.

## Configuration
- JTFRAME_SPIHOST_RX_EN defined: MISO is sampled, and rx_data/rx_valid behave as described above.
- Macro undefined: the MISO shift path is removed, spi_do is ignored, and rx_data=0 and rx_valid=0 permanently. The MOSI side is unchanged.

## Structure
- Package jtframe_spihost_pkg contains:
  - the state enum (IDLE, SETUP, SHIFT, NEXT, HOLD, GAP);
  - command constants UIO_JOYSTICK0=8'h02, UIO_JOYSTICK1=8'h03, UIO_SET_STATUS2=8'h1E, OSD_CMD_WRITE=8'h20.
- Sub-module jtframe_spi_shifter owns:
  - the SCK divider counter;
  - the bit counter;
  - the MOSI/MISO shift registers.
  It exposes `start`, `byte_in`, `done` and `byte_out`.
- The top level holds the FSM, byte sequencing and request latching.

## Test plan
- Reset release: SS2=SS3=1, SCK=0, cmd_ready=1 → request cmd_sel=0, code=8'h02, len=1, data=32'h0000_00A5. Expect SS2 low for the whole frame, 16 SCK pulses, MOSI bits 0000_0010 then 1010_0101, and SS3 never low.
- Cycle count: CLKDIV=4, GAP=8, len=0 → cmd_ready is low for exactly 82 cycles after acceptance.
- Byte order and clamp: code=8'h1E, len=7, data=32'h4433_2211 → 5 bytes sent, 1E 11 22 33 44, with 40 SCK rising edges.
- MISO capture (RX_EN): a responder model returns 8'h5A on the command byte and 8'hC3 on payload byte 0 → rx_valid pulses twice, with rx_data=8'h5A then 8'hC3. With the macro undefined, rx_valid never pulses.
- Back-to-back: hold cmd_valid high with two requests → the second is accepted only after the GAP, both SS are high for ≥GAP cycles between frames, and no request is dropped.
- Reset mid-frame: assert rst during bit 3 of payload byte 1 → on the next cycle SS is high and SCK is 0. A fresh request afterwards produces a complete, correct frame.
